clock_set_ctrl: RTL and testbench

CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

---
 rtl/clock_set_ctrl.sv | 149 ++++++++++++++
 tb/tb_clock_set_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// Settable 24-hour BCD clock: a prescaler produces a one-second tick, and three
// buttons switch between running and setting the hours or minutes.
//
//   state      | meaning
//   S_RUN      | time advances on every prescaler tick
//   S_SET_HOUR | UP steps hours modulo 24; time frozen
//   S_SET_MIN  | UP steps minutes modulo 60; time frozen
//   S_BAD      | unused encoding, recovers to S_RUN
module clock_set_ctrl #(
  parameter int CLK_HZ = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] btn,
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic [1:0] mode,
  output logic       blink
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_HZ / 2);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_SET_HOUR = 2'd1,
    S_SET_MIN  = 2'd2,
    S_BAD      = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [7:0]      hour_q, hour_d;
  logic [7:0]      min_q, min_d;
  logic [7:0]      sec_q, sec_d;
  logic            blink_q, blink_d;

  logic            tick;
  logic            btn_mode;
  logic            btn_sel;
  logic            btn_up;

  // Increment a two-digit BCD value, wrapping to 00 after max.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    logic [7:0] r;
    if (v == max) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  assign tick     = (presc_q == PRESC_LAST);
  assign btn_mode = btn[0];
  assign btn_sel  = btn[1] & ~btn[0];
  assign btn_up   = btn[2] & ~btn[1] & ~btn[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN: begin
        if (btn_mode) state_d = S_SET_HOUR;
      end
      S_SET_HOUR: begin
        if (btn_mode)     state_d = S_RUN;
        else if (btn_sel) state_d = S_SET_MIN;
      end
      S_SET_MIN: begin
        if (btn_mode)     state_d = S_RUN;
        else if (btn_sel) state_d = S_SET_HOUR;
      end
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    presc_d = tick ? '0 : presc_q + PW'(1);
    case (state_q)
      S_RUN: begin
        // Full carry chain resolves in a single cycle.
        if (tick) begin
          sec_d = bcd_inc(sec_q, 8'h59);
          if (sec_q == 8'h59) begin
            min_d = bcd_inc(min_q, 8'h59);
            if (min_q == 8'h59) hour_d = bcd_inc(hour_q, 8'h23);
          end
        end
      end
      S_SET_HOUR: begin
        if (btn_mode) begin
          sec_d   = 8'h00;
          presc_d = '0;
        end else if (btn_up) begin
          hour_d = bcd_inc(hour_q, 8'h23);
        end
      end
      S_SET_MIN: begin
        if (btn_mode) begin
          sec_d   = 8'h00;
          presc_d = '0;
        end else if (btn_up) begin
          min_d = bcd_inc(min_q, 8'h59);
        end
      end
      default: ;
    endcase
    // Evaluated on next-state values so the registered blink lines up with mode.
    blink_d = (state_d != S_RUN) && (presc_d < PRESC_HALF);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      hour_q  <= 8'h00;
      min_q   <= 8'h00;
      sec_q   <= 8'h00;
      blink_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      blink_q <= blink_d;
    end
  end

  assign hour_bcd = hour_q;
  assign min_bcd  = min_q;
  assign sec_bcd  = sec_q;
  assign mode     = state_q;
  assign blink    = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: seconds-of-day reference model compared every cycle,
// plus directed literal checks of the key scenarios.
module tb_clock_set_ctrl;

  localparam int CLK_HZ = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] btn = 3'b000;
  logic [7:0] hour_bcd, min_bcd, sec_bcd;
  logic [1:0] mode;
  logic       blink;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  int m_h = 0, m_m = 0, m_s = 0, m_mode = 0, m_presc = 0;
  int ones;

  clock_set_ctrl #(.CLK_HZ(CLK_HZ)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn      (btn),
    .hour_bcd (hour_bcd),
    .min_bcd  (min_bcd),
    .sec_bcd  (sec_bcd),
    .mode     (mode),
    .blink    (blink)
  );

  always #5 clk = ~clk;

  function automatic int to_bcd(input int n);
    return (n / 10) * 16 + (n % 10);
  endfunction

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: time kept as seconds of the day.
  always @(posedge clk or posedge rst) begin
    int t;
    int nxt;
    bit tk;
    if (rst) begin
      m_h = 0; m_m = 0; m_s = 0; m_mode = 0; m_presc = 0;
    end else begin
      tk  = (m_presc == CLK_HZ - 1);
      nxt = tk ? 0 : m_presc + 1;
      if (m_mode == 0) begin
        if (tk) begin
          t = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
          m_h = t / 3600;
          m_m = (t / 60) % 60;
          m_s = t % 60;
        end
        if (btn[0]) m_mode = 1;
      end else begin
        if (btn[0]) begin
          m_mode = 0;
          m_s    = 0;
          nxt    = 0;
        end else if (btn[1]) begin
          m_mode = (m_mode == 1) ? 2 : 1;
        end else if (btn[2]) begin
          if (m_mode == 1) m_h = (m_h + 1) % 24;
          else             m_m = (m_m + 1) % 60;
        end
      end
      m_presc = nxt;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("hour",  hour_bcd, to_bcd(m_h));
      check("min",   min_bcd,  to_bcd(m_m));
      check("sec",   sec_bcd,  to_bcd(m_s));
      check("mode",  mode,     m_mode);
      check("blink", blink,    (m_mode != 0 && m_presc < CLK_HZ / 2) ? 1 : 0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [2:0] v);
    btn = v;
    @(negedge clk);
    btn = 3'b000;
  endtask

  task automatic press_n(input logic [2:0] v, input int n);
    for (int i = 0; i < n; i++) press(v);
  endtask

  initial begin
    rst = 1'b1;
    cyc(3);
    check("rst_hour", hour_bcd, 8'h00);
    check("rst_min",  min_bcd,  8'h00);
    check("rst_sec",  sec_bcd,  8'h00);
    check("rst_mode", mode,     0);
    check("rst_blink", blink,   0);
    rst = 1'b0;
    chk_en = 1'b1;

    // 600 cycles of free running
    cyc(600);
    check("run600_hour", hour_bcd, 8'h00);
    check("run600_min",  min_bcd,  8'h01);
    check("run600_sec",  sec_bcd,  8'h00);

    // set 23:58, then run to the midnight rollover
    press(3'b001);
    press_n(3'b100, 23);
    check("set23_hour", hour_bcd, 8'h23);
    check("set23_mode", mode, 1);
    press(3'b010);
    press_n(3'b100, 57);
    check("set58_min",  min_bcd, 8'h58);
    check("set58_mode", mode, 2);
    press(3'b001);
    check("exit_sec",  sec_bcd, 8'h00);
    check("exit_mode", mode, 0);
    cyc(1190);
    check("pre_hour", hour_bcd, 8'h23);
    check("pre_min",  min_bcd,  8'h59);
    check("pre_sec",  sec_bcd,  8'h59);
    cyc(10);
    check("wrap_hour", hour_bcd, 8'h00);
    check("wrap_min",  min_bcd,  8'h00);
    check("wrap_sec",  sec_bcd,  8'h00);

    // modulo wrap of hour and minute setting
    press(3'b001);
    press_n(3'b100, 25);
    check("up25_hour", hour_bcd, 8'h01);
    press(3'b010);
    press_n(3'b100, 61);
    check("up61_min",  min_bcd,  8'h01);
    check("up61_hour", hour_bcd, 8'h01);
    cyc(7);
    press(3'b001);
    check("exit2_mode", mode, 0);
    check("exit2_sec",  sec_bcd, 8'h00);
    cyc(9);
    check("restart_sec9", sec_bcd, 8'h00);
    cyc(1);
    check("restart_sec10", sec_bcd, 8'h01);

    // button priority
    press(3'b001);
    press(3'b111);
    check("prio_mode", mode, 0);
    check("prio_hour", hour_bcd, 8'h01);
    press(3'b110);
    check("run_ign_mode", mode, 0);
    check("run_ign_hour", hour_bcd, 8'h01);
    check("run_ign_min",  min_bcd,  8'h01);

    // frozen time and blink in SET_MIN
    press(3'b001);
    press(3'b010);
    ones = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      ones += int'(blink);
    end
    check("blink_ones", ones, 15);
    check("frz_mode", mode, 2);
    check("frz_hour", hour_bcd, 8'h01);
    check("frz_min",  min_bcd,  8'h01);

    // go to 12:34:00 in SET_MIN, then asynchronous reset
    press(3'b010);
    press_n(3'b100, (12 - m_h + 24) % 24);
    press(3'b010);
    press_n(3'b100, (34 - m_m + 60) % 60);
    press(3'b001);
    press(3'b001);
    press(3'b010);
    check("pre_rst_hour", hour_bcd, 8'h12);
    check("pre_rst_min",  min_bcd,  8'h34);
    check("pre_rst_sec",  sec_bcd,  8'h00);
    check("pre_rst_mode", mode, 2);
    #2 rst = 1'b1;
    #1;
    check("arst_hour",  hour_bcd, 8'h00);
    check("arst_min",   min_bcd,  8'h00);
    check("arst_sec",   sec_bcd,  8'h00);
    check("arst_mode",  mode, 0);
    check("arst_blink", blink, 0);
    @(negedge clk);
    btn = 3'b001;
    @(negedge clk);
    btn = 3'b000;
    rst = 1'b0;
    check("rstbtn_mode", mode, 0);
    cyc(9);
    check("first_tick_sec9", sec_bcd, 8'h00);
    cyc(1);
    check("first_tick_sec10", sec_bcd, 8'h01);
    check("first_tick_mode",  mode, 0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
